tx_ip_checksum_insert: RTL and testbench
========================================

TX_IP_CHECKSUM_INSERT -- requirements
Module: tx_ip_checksum_insert

Interface
REQ-001 Parameter DATA_WIDTH, default 512: beat width in bits; SHALL be a multiple of 8 and >= 272, so that the full IPv4 header (bytes 14..33) lies in beat 0.
REQ-002 tx_axis_aclk  input  1  the single clock; all logic rising-edge.
REQ-003 tx_axis_aresetn  input  1  reset, synchronous and active-low.
REQ-004 from_prepend_tx_axis_tdata  input  DATA_WIDTH  frame beat; byte k at bits [8k+7:8k]; Ethernet/IP/UDP headers at bytes 0..41 of the first beat, big-endian.
REQ-005 from_prepend_tx_axis_tkeep  input  DATA_WIDTH/8  byte enables.
REQ-006 from_prepend_tx_axis_tvalid  input  1  beat valid.
REQ-007 from_prepend_tx_axis_tlast  input  1  last beat of frame.
REQ-008 from_prepend_tx_axis_tready  output  1  beat accepted when tvalid & tready.
REQ-009 to_mac_tx_axis_tdata / _tkeep / _tvalid / _tlast  output  DATA_WIDTH / DATA_WIDTH/8 / 1 / 1  frame with the IPv4 header checksum inserted.
REQ-010 to_mac_tx_axis_tready  input  1  downstream ready.
REQ-011 stat_tx_frames  output  32  count of frames (tlast beats) emitted.

Function
REQ-012 The block SHALL be a 2-stage pipeline (S1, S2) with a single global enable en = to_mac_tx_axis_tready.
REQ-013 from_prepend_tx_axis_tready SHALL equal to_mac_tx_axis_tready while reset is deasserted, and SHALL be 0 while reset is asserted.
REQ-014 When en=1, S1 SHALL capture the input beat (valid = input tvalid) and S2 SHALL capture S1. When en=0, all stage registers SHALL hold their values.
REQ-015 Latency SHALL be exactly 2 enabled cycles from input acceptance to appearance at the output; beat order, tkeep and tlast SHALL be preserved unchanged.
REQ-016 A sop register SHALL be 1 after reset, cleared on an accepted beat with tlast=0, and set on an accepted beat with tlast=1; an accepted beat is a header beat iff sop=1 at acceptance, so a single-beat frame is also a header beat.
REQ-017 Header word i (i=0..9) SHALL be {byte 14+2i, byte 15+2i}; word 5 (bytes 24..25, the checksum field) SHALL be excluded from the sum regardless of its input value.
REQ-018 In S1, for a header beat, the block SHALL register the 20-bit unsigned sum of the 9 remaining words (max 0x8FFF7).
REQ-019 In S2, the block SHALL compute f1 = sum[15:0] + sum[19:16] (17 bits), then f2 = f1[15:0] + f1[16] (16 bits), and checksum = ~f2.
REQ-020 For a header beat, output byte 24 SHALL be checksum[15:8] and byte 25 SHALL be checksum[7:0]; all other bytes SHALL pass through unchanged.
REQ-021 Non-header beats and beats with tvalid=0 SHALL pass through unmodified; invalid beats SHALL NOT alter sop.
REQ-022 The block SHALL NOT inspect or alter the UDP checksum (bytes 40..41) or tkeep of any beat.
REQ-023 stat_tx_frames SHALL increment by 1 on each cycle with to_mac_tx_axis_tvalid & tready & tlast, and SHALL wrap from 0xFFFFFFFF to 0.
REQ-024 A stalled output (tvalid=1, tready=0) SHALL keep tdata/tkeep/tlast stable until accepted.

Reset
REQ-025 With tx_axis_aresetn=0 at a clock edge: both stage valids, to_mac_tx_axis_tvalid, tlast, tdata and tkeep SHALL go to 0; stat_tx_frames SHALL go to 0; sop SHALL go to 1.
REQ-026 Reset asserted mid-frame SHALL discard all in-flight beats; the first beat accepted after release SHALL be treated as a header beat.

Verification
REQ-027 Header words 4500 0073 0000 4000 4011 xxxx c0a8 0001 c0a8 00c7 (field = 0x1234), single beat, tready=1 -> output 2 cycles later with bytes 24..25 = B8 61; other bytes and tkeep identical to input.
REQ-028 All IP header bytes = 0x00 -> checksum 0xFFFF; all IP header bytes = 0xFF (sum 0x8FFF7, double fold) -> checksum 0x0000.
REQ-029 3-beat frame, then a 1-beat frame back-to-back -> only the first beat of each frame is modified; a beat-1 pattern at bytes 24..25 passes unchanged; stat_tx_frames = 2.
REQ-030 to_mac_tx_axis_tready low for 5 cycles mid-frame -> from_prepend_tx_axis_tready low in the same cycles; output held stable; no beat lost or duplicated; latency resumes at 2.
REQ-031 Reset pulsed after beat 1 of a 4-beat frame -> output tvalid=0 and stat_tx_frames=0 after the reset edge; the next frame's first beat receives a correct checksum.
REQ-032 Preload stat_tx_frames near 0xFFFFFFFF (force or long run), emit 2 frames -> counter reads 0xFFFFFFFF then 0x00000000.

Source files
------------

// File: rtl/tx_ip_checksum_insert.sv
// Two-stage pipeline that rewrites the IPv4 header checksum (bytes 24..25) in the
// first beat of every frame; all other bytes, tkeep and tlast pass through untouched.
module tx_ip_checksum_insert #(
    parameter int DATA_WIDTH = 512
) (
    input  logic                    tx_axis_aclk,
    input  logic                    tx_axis_aresetn,
    input  logic [DATA_WIDTH-1:0]   from_prepend_tx_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0] from_prepend_tx_axis_tkeep,
    input  logic                    from_prepend_tx_axis_tvalid,
    input  logic                    from_prepend_tx_axis_tlast,
    output logic                    from_prepend_tx_axis_tready,
    output logic [DATA_WIDTH-1:0]   to_mac_tx_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] to_mac_tx_axis_tkeep,
    output logic                    to_mac_tx_axis_tvalid,
    output logic                    to_mac_tx_axis_tlast,
    input  logic                    to_mac_tx_axis_tready,
    output logic [31:0]             stat_tx_frames
);

    localparam int KEEP_WIDTH = DATA_WIDTH / 8;

    logic                  en;
    logic                  accept;
    logic                  sop;
    logic [19:0]           hdr_sum;

    logic                  s1_valid;
    logic                  s1_last;
    logic                  s1_hdr;
    logic [DATA_WIDTH-1:0] s1_data;
    logic [KEEP_WIDTH-1:0] s1_keep;
    logic [19:0]           s1_sum;

    logic [16:0]           fold1;
    logic [15:0]           fold2;
    logic [15:0]           checksum;
    logic [DATA_WIDTH-1:0] s2_data_next;

    // Whole pipeline advances only when the MAC can take a beat.
    assign en                          = to_mac_tx_axis_tready;
    assign from_prepend_tx_axis_tready = to_mac_tx_axis_tready & tx_axis_aresetn;
    assign accept                      = from_prepend_tx_axis_tvalid & from_prepend_tx_axis_tready;

    function automatic logic [15:0] hdr_word(input logic [DATA_WIDTH-1:0] d, input int i);
        return {d[8*(14+2*i) +: 8], d[8*(15+2*i) +: 8]};
    endfunction

    // Sum of the nine header words; word 5 is the checksum field itself and is skipped.
    always_comb begin
        hdr_sum = '0;
        for (int i = 0; i < 10; i++) begin
            if (i != 5) begin
                hdr_sum = hdr_sum + {4'd0, hdr_word(from_prepend_tx_axis_tdata, i)};
            end
        end
    end

    always_ff @(posedge tx_axis_aclk) begin
        if (!tx_axis_aresetn) begin
            sop <= 1'b1;
        end else if (accept) begin
            sop <= from_prepend_tx_axis_tlast;
        end
    end

    always_ff @(posedge tx_axis_aclk) begin
        if (!tx_axis_aresetn) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_hdr   <= 1'b0;
            s1_data  <= '0;
            s1_keep  <= '0;
            s1_sum   <= '0;
        end else if (en) begin
            s1_valid <= from_prepend_tx_axis_tvalid;
            s1_last  <= from_prepend_tx_axis_tlast;
            s1_hdr   <= from_prepend_tx_axis_tvalid & sop;
            s1_data  <= from_prepend_tx_axis_tdata;
            s1_keep  <= from_prepend_tx_axis_tkeep;
            s1_sum   <= hdr_sum;
        end
    end

    // Two folds are needed: the first can itself carry out of bit 15.
    always_comb begin
        fold1        = {1'b0, s1_sum[15:0]} + {13'd0, s1_sum[19:16]};
        fold2        = fold1[15:0] + {15'd0, fold1[16]};
        checksum     = ~fold2;
        s2_data_next = s1_data;
        if (s1_hdr) begin
            s2_data_next[8*24 +: 8] = checksum[15:8];
            s2_data_next[8*25 +: 8] = checksum[7:0];
        end
    end

    always_ff @(posedge tx_axis_aclk) begin
        if (!tx_axis_aresetn) begin
            to_mac_tx_axis_tvalid <= 1'b0;
            to_mac_tx_axis_tlast  <= 1'b0;
            to_mac_tx_axis_tdata  <= '0;
            to_mac_tx_axis_tkeep  <= '0;
        end else if (en) begin
            to_mac_tx_axis_tvalid <= s1_valid;
            to_mac_tx_axis_tlast  <= s1_last;
            to_mac_tx_axis_tdata  <= s2_data_next;
            to_mac_tx_axis_tkeep  <= s1_keep;
        end
    end

    always_ff @(posedge tx_axis_aclk) begin
        if (!tx_axis_aresetn) begin
            stat_tx_frames <= '0;
        end else if (to_mac_tx_axis_tvalid & to_mac_tx_axis_tready & to_mac_tx_axis_tlast) begin
            stat_tx_frames <= stat_tx_frames + 32'd1;
        end
    end

endmodule

// File: tb/tb_tx_ip_checksum_insert.sv
// Directed bench for tx_ip_checksum_insert: table of single-beat headers with
// hand-computed checksums, plus multi-beat, stall, reset and counter-wrap sequences.
module tb_tx_ip_checksum_insert;

    localparam int DW = 512;
    localparam int KW = DW / 8;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          valid;
        logic          last;
    } beat_t;

    typedef struct packed {
        logic [159:0]  hdr;
        logic [15:0]   exp_csum;
        logic [KW-1:0] keep;
        logic [7:0]    seed;
    } hdr_vec_t;

    logic          clk = 1'b0;
    logic          rstn;
    logic [DW-1:0] in_data;
    logic [KW-1:0] in_keep;
    logic          in_valid;
    logic          in_last;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic [KW-1:0] out_keep;
    logic          out_valid;
    logic          out_last;
    logic          mac_ready;
    logic [31:0]   stat;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    tx_ip_checksum_insert #(.DATA_WIDTH(DW)) dut (
        .tx_axis_aclk                (clk),
        .tx_axis_aresetn             (rstn),
        .from_prepend_tx_axis_tdata  (in_data),
        .from_prepend_tx_axis_tkeep  (in_keep),
        .from_prepend_tx_axis_tvalid (in_valid),
        .from_prepend_tx_axis_tlast  (in_last),
        .from_prepend_tx_axis_tready (in_ready),
        .to_mac_tx_axis_tdata        (out_data),
        .to_mac_tx_axis_tkeep        (out_keep),
        .to_mac_tx_axis_tvalid       (out_valid),
        .to_mac_tx_axis_tlast        (out_last),
        .to_mac_tx_axis_tready       (mac_ready),
        .stat_tx_frames              (stat)
    );

    function automatic logic [DW-1:0] build_beat(input logic [159:0] hdr, input logic [7:0] seed);
        logic [DW-1:0] d;
        for (int k = 0; k < KW; k++) d[8*k +: 8] = seed + 8'(k * 7);
        for (int i = 0; i < 10; i++) begin
            d[8*(14+2*i) +: 8] = hdr[159-16*i -: 8];
            d[8*(15+2*i) +: 8] = hdr[151-16*i -: 8];
        end
        return d;
    endfunction

    function automatic logic [DW-1:0] with_csum(input logic [DW-1:0] d, input logic [15:0] c);
        logic [DW-1:0] r;
        r = d;
        r[8*24 +: 8] = c[15:8];
        r[8*25 +: 8] = c[7:0];
        return r;
    endfunction

    function automatic beat_t mk(input logic [DW-1:0] d, input logic [KW-1:0] k,
                                 input logic v, input logic l);
        beat_t b;
        b.data = d; b.keep = k; b.valid = v; b.last = l;
        return b;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input beat_t b);
        in_data  = b.data;
        in_keep  = b.keep;
        in_valid = b.valid;
        in_last  = b.last;
    endtask

    task automatic checkOutput(input string name, input beat_t e);
        total++;
        if (out_valid !== e.valid || out_last !== e.last || out_keep !== e.keep || out_data !== e.data) begin
            bad++;
            $display("[TB] FAIL %s: got v=%0b l=%0b keep=%h data=%h ; want v=%0b l=%0b keep=%h data=%h",
                     name, out_valid, out_last, out_keep, out_data, e.valid, e.last, e.keep, e.data);
        end
    endtask

    task automatic checkValue(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    hdr_vec_t vecs [5];
    beat_t    idle;
    beat_t    seq_in  [5];
    beat_t    seq_exp [5];
    beat_t    p [4];
    beat_t    e [4];
    beat_t    cur;
    beat_t    want;
    int       idx;
    logic     rdy;

    initial begin
        vecs[0] = '{160'h4500_0073_0000_4000_4011_1234_c0a8_0001_c0a8_00c7, 16'hB861, {KW{1'b1}}, 8'h11};
        vecs[1] = '{160'h0000_0000_0000_0000_0000_0000_0000_0000_0000_0000, 16'hFFFF, 64'h0000_0003_FFFF_FFFF, 8'h00};
        vecs[2] = '{160'hffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff, 16'h0000, {KW{1'b1}}, 8'hA5};
        vecs[3] = '{160'h4500_003c_1c46_4000_4006_0000_ac10_0a63_ac10_0a0c, 16'hB1E6, 64'h0000_03FF_FFFF_FFFF, 8'h3C};
        vecs[4] = '{160'h0000_0000_0000_0000_0000_ffff_0000_0000_0000_0000, 16'hFFFF, 64'hF0F0_0FFF_FFFF_FFFF, 8'h77};
        idle = mk('0, '0, 1'b0, 1'b0);

        // Reset state
        rstn      = 1'b0;
        mac_ready = 1'b1;
        applyStimulus(idle);
        tick();
        tick();
        checkOutput("reset_outputs", idle);
        checkValue("reset_stat", stat, 32'd0);
        checkValue("reset_in_ready", {31'd0, in_ready}, 32'd0);
        rstn = 1'b1;
        #1;
        checkValue("run_in_ready", {31'd0, in_ready}, 32'd1);

        // Table of single-beat header frames
        for (int v = 0; v < 5; v++) begin
            cur = mk(build_beat(vecs[v].hdr, vecs[v].seed), vecs[v].keep, 1'b1, 1'b1);
            applyStimulus(cur);
            tick();
            checkOutput($sformatf("vec%0d_latency", v), idle);
            applyStimulus(idle);
            tick();
            want = mk(with_csum(cur.data, vecs[v].exp_csum), vecs[v].keep, 1'b1, 1'b1);
            checkOutput($sformatf("vec%0d_csum", v), want);
        end

        // 3-beat frame with a bubble, then a 1-beat frame back-to-back
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        seq_in[0]  = mk(build_beat(vecs[0].hdr, 8'h21), {KW{1'b1}}, 1'b1, 1'b0);
        seq_exp[0] = mk(with_csum(seq_in[0].data, 16'hB861), {KW{1'b1}}, 1'b1, 1'b0);
        seq_in[1]  = mk(with_csum(build_beat(vecs[3].hdr, 8'h42), 16'hCAFE), 64'h0F0F_FFFF_0000_FFFF, 1'b1, 1'b0);
        seq_exp[1] = seq_in[1];
        seq_in[2]  = mk(build_beat(vecs[1].hdr, 8'h99), 64'h1234_5678_9ABC_DEF0, 1'b0, 1'b1);
        seq_exp[2] = seq_in[2];
        seq_in[3]  = mk(build_beat(vecs[2].hdr, 8'h55), 64'h0000_0000_0000_00FF, 1'b1, 1'b1);
        seq_exp[3] = seq_in[3];
        seq_in[4]  = mk(build_beat(vecs[3].hdr, 8'h66), {KW{1'b1}}, 1'b1, 1'b1);
        seq_exp[4] = mk(with_csum(seq_in[4].data, 16'hB1E6), {KW{1'b1}}, 1'b1, 1'b1);
        for (int k = 0; k < 7; k++) begin
            if (k < 5) applyStimulus(seq_in[k]);
            else       applyStimulus(idle);
            tick();
            if (k >= 1 && k <= 5) checkOutput($sformatf("multi_beat%0d", k - 1), seq_exp[k-1]);
        end
        checkValue("multi_stat", stat, 32'd2);

        // Downstream stall of 5 cycles in the middle of a 4-beat frame
        p[0] = mk(build_beat(vecs[0].hdr, 8'h80), {KW{1'b1}}, 1'b1, 1'b0);
        p[1] = mk(build_beat(vecs[2].hdr, 8'h81), {KW{1'b1}}, 1'b1, 1'b0);
        p[2] = mk(build_beat(vecs[3].hdr, 8'h82), {KW{1'b1}}, 1'b1, 1'b0);
        p[3] = mk(build_beat(vecs[4].hdr, 8'h83), 64'h0000_0000_0000_0FFF, 1'b1, 1'b1);
        e[0] = mk(with_csum(p[0].data, 16'hB861), {KW{1'b1}}, 1'b1, 1'b0);
        e[1] = p[1];
        e[2] = p[2];
        e[3] = p[3];
        idx  = 0;
        for (int s = 0; s <= 10; s++) begin
            rdy       = !(s >= 2 && s <= 6);
            mac_ready = rdy;
            if (idx < 4) applyStimulus(p[idx]);
            else         applyStimulus(idle);
            #1;
            if (s >= 2 && s <= 7) checkValue($sformatf("stall_in_ready%0d", s), {31'd0, in_ready}, {31'd0, rdy});
            tick();
            if (rdy && idx < 4) idx++;
            if (s >= 1 && s <= 6) checkOutput($sformatf("stall_hold%0d", s), e[0]);
            else if (s >= 7 && s <= 9) checkOutput($sformatf("stall_resume%0d", s), e[s-6]);
            else if (s == 10) checkOutput("stall_drain", idle);
        end
        checkValue("stall_stat", stat, 32'd3);

        // Reset pulsed after beat 1 of a 4-beat frame
        applyStimulus(mk(build_beat(vecs[1].hdr, 8'h90), {KW{1'b1}}, 1'b1, 1'b0));
        tick();
        applyStimulus(mk(build_beat(vecs[2].hdr, 8'h91), {KW{1'b1}}, 1'b1, 1'b0));
        tick();
        checkOutput("rst_pre", mk(with_csum(build_beat(vecs[1].hdr, 8'h90), 16'hFFFF), {KW{1'b1}}, 1'b1, 1'b0));
        rstn = 1'b0;
        applyStimulus(mk(build_beat(vecs[3].hdr, 8'h92), {KW{1'b1}}, 1'b1, 1'b0));
        #1;
        checkValue("rst_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        checkOutput("rst_flush", idle);
        checkValue("rst_stat", stat, 32'd0);
        rstn = 1'b1;
        applyStimulus(idle);
        tick();
        checkOutput("rst_discard", idle);
        cur = mk(build_beat(vecs[3].hdr, 8'h31), 64'h0000_00FF_FFFF_FFFF, 1'b1, 1'b1);
        applyStimulus(cur);
        tick();
        applyStimulus(idle);
        tick();
        checkOutput("rst_next_hdr", mk(with_csum(cur.data, 16'hB1E6), cur.keep, 1'b1, 1'b1));
        tick();

        // Frame counter wrap
        force dut.stat_tx_frames = 32'hFFFF_FFFE;
        #1;
        release dut.stat_tx_frames;
        #1;
        checkValue("wrap_preload", stat, 32'hFFFF_FFFE);
        cur = mk(build_beat(vecs[0].hdr, 8'hB0), {KW{1'b1}}, 1'b1, 1'b1);
        applyStimulus(cur);
        tick();
        applyStimulus(mk(build_beat(vecs[2].hdr, 8'hB1), {KW{1'b1}}, 1'b1, 1'b1));
        tick();
        applyStimulus(idle);
        tick();
        checkValue("wrap_ffffffff", stat, 32'hFFFF_FFFF);
        checkOutput("wrap_frame2", mk(with_csum(build_beat(vecs[2].hdr, 8'hB1), 16'h0000), {KW{1'b1}}, 1'b1, 1'b1));
        tick();
        checkValue("wrap_zero", stat, 32'h0000_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
